// File: rtl/vram_arbiter.sv
`default_nettype none
// =============================================================================
// vram_arbiter : shares one synchronous RAM between the CPU bus and the VGA
//                fetcher; VGA priority, bounded CPU starvation, ROM write guard.
// Revision     : 1.0
// =============================================================================
module vram_arbiter #(
  parameter int              AW             = 14,
  parameter int              DW             = 8,
  parameter logic [AW-1:0]   ROM_TOP        = AW'(14'h2000),
  parameter int              VGA_MAX_CONSEC = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpu_rd,
  input  logic          i_cpu_wr,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_ready,
  input  logic          i_vga_rd,
  input  logic [AW-1:0] i_vga_addr,
  output logic [DW-1:0] o_vga_data,
  output logic          o_vga_ready,
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata,
  output logic          o_rom_viol
);

  localparam int            SW         = $clog2(VGA_MAX_CONSEC + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(VGA_MAX_CONSEC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_streak;
  logic          r_owner_vga;
  logic          r_ram_en;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_vga_data;
  logic          r_cpu_ready;
  logic          r_vga_ready;
  logic          r_rom_viol;

  logic w_cpu_req;
  logic w_vga_win;
  logic w_grant;

  assign w_cpu_req = i_cpu_rd | i_cpu_wr;
  assign w_vga_win = i_vga_rd & ~(w_cpu_req & (r_streak == STREAK_MAX));
  assign w_grant   = w_vga_win | w_cpu_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ACC;
      S_ACC:   w_next = S_RESP;
      S_RESP:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_streak    <= '0;
      r_owner_vga <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cpu_rdata <= '0;
      r_vga_data  <= '0;
      r_cpu_ready <= 1'b0;
      r_vga_ready <= 1'b0;
      r_rom_viol  <= 1'b0;
    end else begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_vga_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_cpu_req) r_streak <= '0;
          if (w_vga_win) begin
            r_owner_vga <= 1'b1;
            r_ram_en    <= 1'b1;
            r_ram_addr  <= i_vga_addr;
            if (w_cpu_req && r_streak != STREAK_MAX) r_streak <= r_streak + 1'b1;
          end else if (w_cpu_req) begin
            r_owner_vga <= 1'b0;
            r_ram_en    <= 1'b1;
            r_ram_addr  <= i_cpu_addr;
            r_ram_wdata <= i_cpu_wdata;
            r_streak    <= '0;
            // Writes into the ROM region are dropped and flagged, still completing normally.
            if (i_cpu_wr) begin
              if (i_cpu_addr >= ROM_TOP) r_ram_we   <= 1'b1;
              else                       r_rom_viol <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (r_owner_vga) begin
            r_vga_data  <= i_ram_rdata;
            r_vga_ready <= 1'b1;
          end else begin
            r_cpu_rdata <= i_ram_rdata;
            r_cpu_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset during ACC must not let the aborted access reach the RAM on that edge.
  assign o_ram_en    = r_ram_en & ~i_rst;
  assign o_ram_we    = r_ram_we & ~i_rst;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ready = r_cpu_ready;
  assign o_vga_data  = r_vga_data;
  assign o_vga_ready = r_vga_ready;
  assign o_rom_viol  = r_rom_viol;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_vram_arbiter : directed scoreboard bench for vram_arbiter with a RAM model.
// Revision        : 1.0
// =============================================================================
module tb_vram_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_cpu_rd, i_cpu_wr, i_vga_rd;
  logic [AW-1:0] i_cpu_addr, i_vga_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic [DW-1:0] o_cpu_rdata, o_vga_data;
  logic          o_cpu_ready, o_vga_ready;
  logic          o_ram_en, o_ram_we, o_rom_viol;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata = '0;

  vram_arbiter #(.AW(AW), .DW(DW), .ROM_TOP(14'h2000), .VGA_MAX_CONSEC(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cpu_rd(i_cpu_rd), .i_cpu_wr(i_cpu_wr), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_rdata(o_cpu_rdata), .o_cpu_ready(o_cpu_ready),
    .i_vga_rd(i_vga_rd), .i_vga_addr(i_vga_addr), .o_vga_data(o_vga_data),
    .o_vga_ready(o_vga_ready), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata),
    .o_rom_viol(o_rom_viol)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Synchronous RAM model with a backdoor preload port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge i_clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (o_ram_en) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      i_ram_rdata <= mem[o_ram_addr];
    end
  end

  typedef struct {
    int cyc;
    int data;
    bit chk;
  } exp_t;
  exp_t cpu_q[$];
  exp_t vga_q[$];

  int total = 0;
  int bad   = 0;
  int k;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge i_clk);
      chk("ready_exclusive", 32'(o_cpu_ready & o_vga_ready), 0);
      chk("we_only_with_en", 32'(o_ram_we & ~o_ram_en), 0);
      if (o_cpu_ready) begin
        if (cpu_q.size() == 0) chk("cpu_ready_unexpected", 32'(o_cpu_ready), 0);
        else begin
          e = cpu_q.pop_front();
          chk("cpu_ready_cycle", cyc, e.cyc);
          if (e.chk) chk("cpu_rdata", 32'(o_cpu_rdata), e.data);
        end
      end
      if (o_vga_ready) begin
        if (vga_q.size() == 0) chk("vga_ready_unexpected", 32'(o_vga_ready), 0);
        else begin
          e = vga_q.pop_front();
          chk("vga_ready_cycle", cyc, e.cyc);
          chk("vga_data", 32'(o_vga_data), e.data);
        end
      end
    end
  endtask

  task automatic preload(input int a, input int d);
    bd_addr = a[AW-1:0];
    bd_data = d[DW-1:0];
    bd_we   = 1'b1;
    @(posedge i_clk);
    #1 bd_we = 1'b0;
  endtask

  // Called at a negedge; holds the request until the ready pulse is seen.
  task automatic cpu_req(input int wr, input int a, input int wd, input int ed, input int ecyc);
    exp_t e;
    bit   seen;
    e.cyc = ecyc; e.data = ed; e.chk = (wr == 0);
    cpu_q.push_back(e);
    i_cpu_addr  = a[AW-1:0];
    i_cpu_wdata = wd[DW-1:0];
    i_cpu_wr    = (wr != 0);
    i_cpu_rd    = (wr == 0);
    seen = 1'b0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge i_clk);
      seen = o_cpu_ready;
    end
    if (!seen) chk("cpu_timeout", 0, 1);
    i_cpu_rd = 1'b0;
    i_cpu_wr = 1'b0;
  endtask

  task automatic vga_req(input int a, input int ed, input int ecyc);
    exp_t e;
    bit   seen;
    e.cyc = ecyc; e.data = ed; e.chk = 1'b1;
    vga_q.push_back(e);
    i_vga_addr = a[AW-1:0];
    i_vga_rd   = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge i_clk);
      seen = o_vga_ready;
    end
    if (!seen) chk("vga_timeout", 0, 1);
    i_vga_rd = 1'b0;
  endtask

  task automatic wait_to(input int at);
    while (cyc < at) @(negedge i_clk);
  endtask

  task automatic probe(input int at, input string nm, input int en, input int we, input int a);
    wait_to(at);
    chk({nm, "_en"}, 32'(o_ram_en), en);
    chk({nm, "_we"}, 32'(o_ram_we), we);
    chk({nm, "_addr"}, 32'(o_ram_addr), a);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    i_cpu_rd = 0; i_cpu_wr = 0; i_vga_rd = 0;
    i_cpu_addr = '0; i_vga_addr = '0; i_cpu_wdata = '0;
    fork monitor(); join_none

    preload('h2400, 'hA5);
    preload('h1FFF, 'h77);
    preload('h2100, 'h3C);
    preload('h0100, 'hC3);
    for (int i = 0; i < 6; i++) preload('h0200 + i, 'h10 + i);
    preload('h2200, 'h99);
    preload('h3000, 'h11);
    idle(1);
    i_rst = 1'b0;
    idle(1);

    // Reset state
    chk("rst_ram_en", 32'(o_ram_en), 0);
    chk("rst_ram_we", 32'(o_ram_we), 0);
    chk("rst_ram_addr", 32'(o_ram_addr), 0);
    chk("rst_ram_wdata", 32'(o_ram_wdata), 0);
    chk("rst_cpu_rdata", 32'(o_cpu_rdata), 0);
    chk("rst_vga_data", 32'(o_vga_data), 0);
    chk("rst_rom_viol", 32'(o_rom_viol), 0);
    chk("rst_streak", 32'(dut.r_streak), 0);

    // CPU read
    k = cyc;
    fork
      cpu_req(0, 'h2400, 0, 'hA5, k + 3);
      probe(k + 1, "rd_acc", 1, 0, 'h2400);
    join
    idle(1);
    chk("rd_c4_ready", 32'(o_cpu_ready), 0);
    chk("rd_c4_en", 32'(o_ram_en), 0);
    idle(2);

    // ROM protection then first writable address
    k = cyc;
    fork
      cpu_req(1, 'h1FFF, 'h55, 0, k + 3);
      probe(k + 1, "rom_acc", 1, 0, 'h1FFF);
    join
    chk("rom_viol_set", 32'(o_rom_viol), 1);
    chk("rom_mem_kept", 32'(mem['h1FFF]), 'h77);
    idle(1);
    k = cyc;
    fork
      cpu_req(1, 'h2000, 'h55, 0, k + 3);
      probe(k + 1, "wr_acc", 1, 1, 'h2000);
    join
    chk("wr_wdata_reg", 32'(o_ram_wdata), 'h55);
    chk("wr_mem_2000", 32'(mem['h2000]), 'h55);
    idle(2);

    // Simultaneous requests: VGA first
    k = cyc;
    fork
      cpu_req(0, 'h2100, 0, 'h3C, k + 7);
      vga_req('h0100, 'hC3, k + 3);
    join
    idle(2);

    // Starvation bound: 4 VGA grants, CPU, then VGA again
    k = cyc;
    fork
      cpu_req(0, 'h2200, 0, 'h99, k + 19);
      begin
        vga_req('h0200, 'h10, k + 3);
        vga_req('h0201, 'h11, k + 7);
        vga_req('h0202, 'h12, k + 11);
        vga_req('h0203, 'h13, k + 15);
        vga_req('h0204, 'h14, k + 23);
        vga_req('h0205, 'h15, k + 27);
      end
      probe(k + 17, "starve_cpu", 1, 0, 'h2200);
      probe(k + 21, "starve_vga", 1, 0, 'h0204);
      begin
        wait_to(k + 16);
        chk("streak_sat", 32'(dut.r_streak), 4);
        wait_to(k + 17);
        chk("streak_clr", 32'(dut.r_streak), 0);
      end
    join
    idle(2);

    // Reset asserted before ACC
    i_cpu_addr = 14'h3000; i_cpu_wdata = 8'hAA; i_cpu_wr = 1'b1; i_rst = 1'b1;
    idle(1);
    chk("rstA_en", 32'(o_ram_en), 0);
    chk("rstA_viol", 32'(o_rom_viol), 0);
    i_rst = 1'b0; i_cpu_wr = 1'b0;
    idle(4);
    chk("rstA_mem", 32'(mem['h3000]), 'h11);

    // Reset asserted in ACC
    i_cpu_wr = 1'b1;
    idle(1);
    chk("rstB_acc_en", 32'(o_ram_en), 1);
    i_rst = 1'b1;
    idle(1);
    chk("rstB_en", 32'(o_ram_en), 0);
    chk("rstB_we", 32'(o_ram_we), 0);
    chk("rstB_addr", 32'(o_ram_addr), 0);
    chk("rstB_wdata", 32'(o_ram_wdata), 0);
    chk("rstB_cpu_rdata", 32'(o_cpu_rdata), 0);
    chk("rstB_vga_data", 32'(o_vga_data), 0);
    chk("rstB_cpu_ready", 32'(o_cpu_ready), 0);
    i_rst = 1'b0; i_cpu_wr = 1'b0;
    idle(4);
    chk("rstB_mem", 32'(mem['h3000]), 'h11);
    k = cyc;
    cpu_req(0, 'h3000, 0, 'h11, k + 3);
    idle(2);

    // Back-to-back CPU writes
    k = cyc;
    cpu_req(1, 'h2400, 'h01, 0, k + 3);
    cpu_req(1, 'h2401, 'h02, 0, k + 7);
    cpu_req(1, 'h2402, 'h03, 0, k + 11);
    idle(2);
    chk("b2b_mem0", 32'(mem['h2400]), 'h01);
    chk("b2b_mem1", 32'(mem['h2401]), 'h02);
    chk("b2b_mem2", 32'(mem['h2402]), 'h03);

    chk("sb_cpu_drained", cpu_q.size(), 0);
    chk("sb_vga_drained", vga_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port memory arbiter sharing the 16 KB game RAM/ROM array between the i8080 CPU bus and the VGA frame fetcher, both in the `i_clk` domain. It grants one access at a time, gives the VGA fetcher priority with a bounded-starvation guarantee for the CPU, and drops CPU writes into the ROM region. It sits between the CPU/VGA request ports and the raw synchronous RAM macro. The VGA request port is already synchronized into `i_clk` upstream.

## Interface
- `AW`, 14, address width.
- `DW`, 8, data width.
- `ROM_TOP`, 14'h2000, first writable address; writes below it are suppressed.
- `VGA_MAX_CONSEC`, 4, maximum consecutive VGA grants while a CPU request is pending (≥1).

Ports:
- `i_clk` in 1: clock. All logic is in this single domain.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_cpu_rd` in 1: CPU read request, level, held until `o_cpu_ready`.
- `i_cpu_wr` in 1: CPU write request, level, held until `o_cpu_ready`.
- `i_cpu_addr` in AW: CPU address.
- `i_cpu_wdata` in DW: CPU write data.
- `o_cpu_rdata` out DW: CPU read data, registered, valid while `o_cpu_ready`=1.
- `o_cpu_ready` out 1: one-cycle completion pulse.
- `i_vga_rd` in 1: VGA read request, level, held until `o_vga_ready`.
- `i_vga_addr` in AW: VGA address.
- `o_vga_data` out DW: VGA read data, registered.
- `o_vga_ready` out 1: one-cycle completion pulse.
- `o_ram_en` out 1: RAM enable.
- `o_ram_we` out 1: RAM write enable.
- `o_ram_addr` out AW: RAM address.
- `o_ram_wdata` out DW: RAM write data.
- `i_ram_rdata` in DW: RAM read data, valid 1 cycle after `o_ram_en`.
- `o_rom_viol` out 1: sticky flag, set by a suppressed ROM write; cleared only by reset.

## Operation
- FSM states: IDLE → ACC → RESP → DONE → IDLE.
- **IDLE:** evaluate requests and pick a winner.
  - VGA wins if `i_vga_rd`=1, unless the CPU is requesting and `streak`==`VGA_MAX_CONSEC`; in that case the CPU wins.
  - On a grant, register the address, write enable and write data into the `o_ram_*` outputs, latch the owner, and go to ACC.
  - With no request, remain in IDLE with `o_ram_en`=0.
- **ACC:** `o_ram_en`=1 for exactly this cycle. `o_ram_we`=1 only for a CPU write with `i_cpu_addr` ≥ `ROM_TOP`.
  - A CPU write below `ROM_TOP` keeps `o_ram_we`=0 and sets `o_rom_viol`.
  - Go to RESP.
- **RESP:** capture `i_ram_rdata` into the owner's data register; go to DONE.
  - Writes also update the CPU data register, with don't-care content.
- **DONE:** the owner's ready output is 1 for exactly this cycle; go to IDLE.
- The requester must deassert its request by the edge ending DONE. A request still high in the following IDLE cycle is a new access.
- `i_cpu_rd` and `i_cpu_wr` both high is treated as a write.
- `streak` counter, width clog2(`VGA_MAX_CONSEC`+1):
  - increments (saturating) on each VGA grant made while a CPU request is pending;
  - resets to 0 on a CPU grant, and whenever IDLE sees no CPU request.
- Request inputs and addresses are sampled only in IDLE. Changes during ACC, RESP or DONE are ignored.

## Timing
- Fixed latency: request sampled at the IDLE edge of cycle 0; RAM enabled in cycle 1; data captured at the end of cycle 2; ready in cycle 3.
- Reads and writes have identical latency. Throughput is one access per 4 cycles.
- Back-to-back accesses: the earliest next grant is the IDLE cycle 4.
- Reset values:
  - state = IDLE;
  - all outputs 0: `o_ram_en`, `o_ram_we`, `o_ram_addr`, `o_ram_wdata`, `o_cpu_rdata`, `o_vga_data`, `o_cpu_ready`, `o_vga_ready`, `o_rom_viol`;
  - `streak` = 0.
- Reset mid-transaction: the next cycle is IDLE with all outputs 0. No RAM write and no ready pulse is issued for the aborted access.
- `o_ram_we` is never 1 outside ACC. The two ready outputs are never high in the same cycle.

## Test plan
- **CPU read:** preload RAM[14'h2400]=8'hA5; assert `i_cpu_rd` with `i_cpu_addr`=14'h2400 → `o_ram_en` in cycle 1, `o_cpu_ready`=1 and `o_cpu_rdata`=8'hA5 in cycle 3, nothing in cycle 4.
- **ROM protection:** CPU write 8'h55 to 14'h1FFF → `o_ram_we` stays 0, `o_rom_viol`=1, ready in cycle 3, RAM unchanged. A write to 14'h2000 → `o_ram_we`=1 in cycle 1, RAM[14'h2000]=8'h55.
- **Simultaneous requests:** `i_cpu_rd` and `i_vga_rd` rise in the same cycle → VGA is served first (ready cycle 3), then CPU (ready cycle 7).
- **Starvation bound:** VGA requests continuously and the CPU holds `i_cpu_rd` → exactly 4 VGA grants, then a CPU grant, then VGA resumes. `streak` returns to 0 after the CPU grant.
- **Reset mid-operation:** assert `i_rst` in ACC of a write to 14'h3000 → no ready pulse, all outputs 0 the next cycle. If asserted before ACC, RAM is unchanged; the FSM then accepts a new request normally.
- **Back-to-back CPU writes:** writes to 14'h2400, 14'h2401, 14'h2402 → ready pulses in cycles 3, 7, 11 and all three RAM locations written.
